// File: rtl/cv32e40x_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40x_div_seq
// Brief    : Sequential restoring divider for RV32M; borrows the ALU CLZ and
//            shifter to normalise the divisor, then makes one quotient bit per cycle.
// Revision : 1.0
// ============================================================================

package cv32e40x_div_pkg;
    typedef enum logic [1:0] {
        DIV_DIV  = 2'd0,
        DIV_DIVU = 2'd1,
        DIV_REM  = 2'd2,
        DIV_REMU = 2'd3
    } div_opcode_e;
endpackage

module cv32e40x_div_seq
    import cv32e40x_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  div_opcode_e operator_i,
    input  logic [31:0] opa_i,
    input  logic [31:0] opb_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        kill_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] result_o,
    output logic        alu_clz_en_o,
    output logic [31:0] alu_clz_data_rev_o,
    input  logic [5:0]  alu_clz_result_i,
    output logic        alu_shift_en_o,
    output logic [5:0]  alu_shift_amt_o,
    output logic [31:0] alu_muldiv_operand_b_o,
    input  logic [31:0] alu_op_b_shifted_i
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_SHIFT = 3'd2,
        S_DIV   = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e      r_state;
    logic        r_is_rem;
    logic        r_a_neg;
    logic        r_b_neg;
    logic [31:0] r_abs_a;
    logic [31:0] r_abs_b;
    logic [31:0] r_rem;
    logic [31:0] r_d;
    logic [31:0] r_q;
    logic [4:0]  r_cnt;
    logic [4:0]  r_iter;

    logic        w_signed;
    logic        w_is_rem;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_abs_b_rev;
    logic        w_ge;
    logic [31:0] w_rem_next;
    logic [31:0] w_q_next;
    logic [31:0] w_quot_fix;
    logic [31:0] w_rem_fix;
    logic [31:0] w_orig_a;

    assign w_signed = (operator_i == DIV_DIV) || (operator_i == DIV_REM);
    assign w_is_rem = (operator_i == DIV_REM) || (operator_i == DIV_REMU);
    assign w_a_neg  = w_signed & opa_i[31];
    assign w_b_neg  = w_signed & opb_i[31];
    // 0x80000000 negates to itself, which is still the right unsigned magnitude
    assign w_abs_a  = w_a_neg ? (32'd0 - opa_i) : opa_i;
    assign w_abs_b  = w_b_neg ? (32'd0 - opb_i) : opb_i;

    always_comb begin
        w_abs_b_rev = '0;
        for (int i = 0; i < 32; i++) begin
            w_abs_b_rev[i] = w_abs_b[31-i];
        end
    end

    assign w_ge       = (r_rem >= r_d);
    assign w_rem_next = w_ge ? (r_rem - r_d) : r_rem;
    assign w_q_next   = {r_q[30:0], w_ge};
    assign w_quot_fix = (r_a_neg ^ r_b_neg) ? (32'd0 - w_q_next) : w_q_next;
    assign w_rem_fix  = r_a_neg ? (32'd0 - w_rem_next) : w_rem_next;
    // Divide-by-zero remainder is the original dividend, recovered from |a|
    assign w_orig_a   = r_a_neg ? (32'd0 - r_abs_a) : r_abs_a;

    assign alu_muldiv_operand_b_o = r_abs_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state            <= S_IDLE;
            r_is_rem           <= 1'b0;
            r_a_neg            <= 1'b0;
            r_b_neg            <= 1'b0;
            r_abs_a            <= '0;
            r_abs_b            <= '0;
            r_rem              <= '0;
            r_d                <= '0;
            r_q                <= '0;
            r_cnt              <= '0;
            r_iter             <= '0;
            ready_o            <= 1'b1;
            valid_o            <= 1'b0;
            result_o           <= '0;
            alu_clz_en_o       <= 1'b0;
            alu_clz_data_rev_o <= '0;
            alu_shift_en_o     <= 1'b0;
            alu_shift_amt_o    <= '0;
        end else if (kill_i) begin
            r_state            <= S_IDLE;
            ready_o            <= 1'b1;
            valid_o            <= 1'b0;
            result_o           <= '0;
            alu_clz_en_o       <= 1'b0;
            alu_clz_data_rev_o <= '0;
            alu_shift_en_o     <= 1'b0;
            alu_shift_amt_o    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid_i) begin
                        r_state            <= S_INIT;
                        ready_o            <= 1'b0;
                        r_is_rem           <= w_is_rem;
                        r_a_neg            <= w_a_neg;
                        r_b_neg            <= w_b_neg;
                        r_abs_a            <= w_abs_a;
                        r_abs_b            <= w_abs_b;
                        alu_clz_en_o       <= 1'b1;
                        alu_clz_data_rev_o <= w_abs_b_rev;
                    end
                end
                S_INIT: begin
                    alu_clz_en_o       <= 1'b0;
                    alu_clz_data_rev_o <= '0;
                    if (alu_clz_result_i == 6'd32) begin
                        r_state  <= S_DONE;
                        valid_o  <= 1'b1;
                        result_o <= r_is_rem ? w_orig_a : 32'hFFFF_FFFF;
                    end else begin
                        r_state         <= S_SHIFT;
                        r_cnt           <= alu_clz_result_i[4:0];
                        alu_shift_en_o  <= 1'b1;
                        alu_shift_amt_o <= {1'b0, alu_clz_result_i[4:0]};
                    end
                end
                S_SHIFT: begin
                    alu_shift_en_o  <= 1'b0;
                    alu_shift_amt_o <= '0;
                    r_d             <= alu_op_b_shifted_i;
                    r_rem           <= r_abs_a;
                    r_q             <= '0;
                    r_iter          <= '0;
                    r_state         <= S_DIV;
                end
                S_DIV: begin
                    r_rem  <= w_rem_next;
                    r_q    <= w_q_next;
                    r_d    <= {1'b0, r_d[31:1]};
                    r_iter <= r_iter + 5'd1;
                    if (r_iter == r_cnt) begin
                        r_state  <= S_DONE;
                        valid_o  <= 1'b1;
                        result_o <= r_is_rem ? w_rem_fix : w_quot_fix;
                    end
                end
                S_DONE: begin
                    if (ready_i) begin
                        r_state  <= S_IDLE;
                        valid_o  <= 1'b0;
                        ready_o  <= 1'b1;
                        result_o <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/cv32e40x_div_seq.md
# cv32e40x_div_seq

Multi-cycle sequential divider for RV32M DIV/DIVU/REM/REMU, sitting in EX alongside the ALU. It owns no CLZ or barrel shifter. It drives the ALU's divider-side CLZ and shifter ports to normalise the divisor, then runs a restoring shift-subtract loop. It produces one quotient bit per cycle, plus the sign fix-up and RISC-V corner-case results, behind a valid/ready handshake on both sides.

## Interface
- No parameters.
- clk  in  1  core clock.
- rst_n  in  1  reset, asynchronous, active-low.
- operator_i  in  div_opcode_e  DIV_DIV / DIV_DIVU / DIV_REM / DIV_REMU; sampled on accept.
- opa_i  in  32  dividend; sampled on accept.
- opb_i  in  32  divisor; sampled on accept.
- valid_i  in  1  request valid.
- ready_o  out  1  block can accept; high only in IDLE.
- kill_i  in  1  synchronous abort (flush).
- valid_o  out  1  result valid; held until taken.
- ready_i  in  1  consumer takes result.
- result_o  out  32  quotient (DIV/DIVU) or remainder (REM/REMU).
- alu_clz_en_o  out  1  to ALU div_clz_en_i.
- alu_clz_data_rev_o  out  32  to ALU div_clz_data_rev_i; bit-reversed |b|.
- alu_clz_result_i  in  6  from ALU div_clz_result_o; leading zeros of |b|, 32 if zero.
- alu_shift_en_o  out  1  to ALU div_shift_en_i.
- alu_shift_amt_o  out  6  to ALU div_shift_amt_i.
- alu_muldiv_operand_b_o  out  32  to ALU muldiv_operand_b_i; |b| register.
- alu_op_b_shifted_i  in  32  from ALU div_op_b_shifted_o; |b| << amt.

## Operation
- Signed ops (DIV, REM): a_neg = a[31], b_neg = b[31].
- Unsigned ops: a_neg = b_neg = 0.
- Magnitudes |a| and |b| are computed and registered on accept, as 32-bit two's-complement negation when the sign flag is set. 0x80000000 stays 0x80000000, which is a correct unsigned magnitude.

States:
- IDLE: ready_o=1.
  - valid_i=1 on a clock edge: latch op, signs, |a|, |b|; go to INIT.
- INIT: alu_clz_en_o=1, alu_clz_data_rev_o = bitreverse(|b|).
  - If alu_clz_result_i == 32 (b==0): quotient = 0xFFFFFFFF, remainder = a (original, unsigned-equal); go to DONE.
  - Otherwise: cnt <= alu_clz_result_i[4:0]; go to SHIFT.
- SHIFT: alu_shift_en_o=1, alu_shift_amt_o = {1'b0, cnt}.
  - d <= alu_op_b_shifted_i; rem <= |a|; q <= 0; go to DIV.
- DIV: runs cnt+1 cycles; each cycle:
  - if rem >= d: rem -= d, q = {q[30:0], 1}; else q = {q[30:0], 0}.
  - d >>= 1.
  - After the final iteration (iteration counter == cnt), go to DONE.
  - Comparison and subtraction are 32-bit unsigned; no overflow is possible.
- DONE: valid_o=1.
  - result_o = quotient, negated if a_neg ^ b_neg; or remainder, negated if a_neg.
  - Fix-up is skipped for divide-by-zero.
  - On ready_i=1, go to IDLE.
- Overflow (DIV 0x80000000 / -1) needs no special case: it yields quotient 0x80000000 and remainder 0.
- alu_clz_en_o is high only in INIT; alu_shift_en_o is high only in SHIFT. Otherwise both are 0, so the ALU keeps serving normal ops.
- kill_i=1 in any state: go to IDLE next edge, valid_o=0, no result. kill_i has priority over accept and over ready_i.

## Timing
- Reset values:
  - state IDLE.
  - ready_o=1, valid_o=0, result_o=0.
  - alu_clz_en_o=0, alu_shift_en_o=0.
  - alu_shift_amt_o=0, alu_clz_data_rev_o=0, alu_muldiv_operand_b_o=0.
  - All internal registers 0.
- Latency is counted from the accepting edge to the first cycle with valid_o=1:
  - b≠0: clz(|b|)+4 cycles (INIT 1, SHIFT 1, DIV clz+1, DONE 1). Range is 4 (|b| ≥ 2^31) to 35 (|b|=1).
  - b=0: 2 cycles (INIT, DONE).
- result_o is registered and stable for the whole DONE residency. It is 0 outside DONE.
- ready_o is 0 from the cycle after accept until the cycle after the result is taken. Back-to-back issue has a one-cycle IDLE bubble minimum.
- valid_o, once high, stays high with constant result_o until ready_i or kill_i.
- Reset asserted mid-operation returns immediately to reset values; no partial result is emitted.

## Test plan
- DIVU 100/7 -> result 14, valid_o exactly 33 cycles after accept (clz(7)=29); REMU same operands -> 2.
- DIV 0xFFFFFF9C(-100)/7 -> 0xFFFFFFF2; REM same operands -> 0xFFFFFFFE; DIV 100/0xFFFFFFF9 -> 0xFFFFFFF2, REM -> 2.
- DIVU 5/0 -> 0xFFFFFFFF after 2 cycles; REM 0xFFFFFFFB/0 -> 0xFFFFFFFB; alu_shift_en_o never asserted.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000 in 35 cycles; REM -> 0; DIVU 0xFFFFFFFF/0x80000000 -> 1 in 4 cycles.
- ready_i held low 10 cycles in DONE -> valid_o and result_o constant, ready_o stays 0; new valid_i ignored until 1 cycle after take.
- kill_i pulsed in DIV iteration 5 -> IDLE next cycle, valid_o never rises, next DIVU 9/3 -> 3. rst_n dropped mid-DIV -> all outputs at reset values asynchronously.
